// File: rtl/npu_pool_pkg.sv
// ----------------------------------------------------------------------------
//  npu_pool_pkg : shared types and helpers for the average_pool sequencer
//  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package npu_pool_pkg;

    localparam int CNT_W  = 21;
    localparam int DIM_W  = 5;
    localparam int CLS_W  = 10;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } pool_state_e;

    // Bytes the pool will emit for one layer: C+1 when averaging, (D+1)^2*(C+1) otherwise.
    function automatic logic [CNT_W-1:0] calc_total(
        input logic             avg_en,
        input logic [DIM_W-1:0] dim,
        input logic [CLS_W-1:0] cls
    );
        logic [CNT_W-1:0] side;
        logic [CNT_W-1:0] classes;
        logic [CNT_W-1:0] result;
        side    = CNT_W'(dim) + CNT_W'(1);
        classes = CNT_W'(cls) + CNT_W'(1);
        if (avg_en) begin
            result = classes;
        end else begin
            result = side * side * classes;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/skid_fifo2.sv
// ----------------------------------------------------------------------------
//  skid_fifo2 : 2-entry byte FIFO with registered head output
//  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module skid_fifo2
    import npu_pool_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [BYTE_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [BYTE_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [1:0]        count_q, count_d;
    logic [BYTE_W-1:0] head_q, head_d;
    logic [BYTE_W-1:0] tail_q, tail_d;
    logic              w_do_pop;
    logic              w_do_push;

    assign w_do_pop  = pop_i && (count_q != 2'd0);
    assign w_do_push = push_i && ((count_q != 2'd2) || w_do_pop);

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (count_q)
            2'd0: begin
                if (w_do_push) begin
                    head_d  = push_data_i;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                case ({w_do_push, w_do_pop})
                    2'b11:   head_d = push_data_i;
                    2'b10: begin
                        tail_d  = push_data_i;
                        count_d = 2'd2;
                    end
                    2'b01:   count_d = 2'd0;
                    default: count_d = count_q;
                endcase
            end
            default: begin
                // Full: a pop promotes the tail; a simultaneous push refills it.
                if (w_do_pop) begin
                    head_d = tail_q;
                    if (w_do_push) begin
                        tail_d = push_data_i;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign data_o  = head_q;
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);

endmodule

`default_nettype wire

// File: rtl/avg_pool_seq_ctrl.sv
// ----------------------------------------------------------------------------
//  avg_pool_seq_ctrl : layer sequencer for average_pool (command -> start -> byte stream -> done)
//  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module avg_pool_seq_ctrl #(
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 21
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            cmd_valid_i,
    output logic                            cmd_ready_o,
    input  logic                            cmd_avg_en_i,
    input  logic [npu_pool_pkg::DIM_W-1:0]  cmd_layer_dim_i,
    input  logic [npu_pool_pkg::CLS_W-1:0]  cmd_classes_i,
    output logic                            pool_start_o,
    output logic                            pool_avg_en_o,
    output logic [npu_pool_pkg::DIM_W-1:0]  pool_layer_dim_o,
    output logic [npu_pool_pkg::CLS_W-1:0]  pool_classes_o,
    output logic                            pool_rd_en_o,
    input  logic [npu_pool_pkg::BYTE_W-1:0] pool_rd_data_i,
    input  logic                            pool_empty_i,
    output logic [npu_pool_pkg::BYTE_W-1:0] m_data_o,
    output logic                            m_valid_o,
    input  logic                            m_ready_i,
    output logic                            m_last_o,
    output logic                            busy_o,
    output logic                            done_o
);

    import npu_pool_pkg::*;

    pool_state_e      state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             start_q, start_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             avg_en_q, avg_en_d;
    logic [DIM_W-1:0] dim_q, dim_d;
    logic [CLS_W-1:0] cls_q, cls_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic             inflight_q, inflight_d;

    logic             w_accept;
    logic             w_rd_en;
    logic             w_pop;
    logic             w_is_last;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [1:0]       w_occ;
    logic             w_room;

    assign w_occ     = w_fifo_full ? 2'd2 : (w_fifo_empty ? 2'd0 : 2'd1);
    // Count the read in flight so the skid buffer can never be overrun.
    assign w_room    = ({1'b0, w_occ} + {2'b00, inflight_q}) < 3'(BUF_DEPTH);
    assign w_accept  = (state_q == ST_IDLE) && cmd_valid_i && cmd_ready_q;
    assign w_rd_en   = (state_q == ST_RUN) && !pool_empty_i && w_room && (issued_q < total_q);
    assign w_pop     = !w_fifo_empty && m_ready_i;
    assign w_is_last = (sent_q == total_q - CNT_W'(1));

    always_comb begin
        state_d    = state_q;
        avg_en_d   = avg_en_q;
        dim_d      = dim_q;
        cls_d      = cls_q;
        total_d    = total_q;
        issued_d   = issued_q;
        sent_d     = sent_q;
        inflight_d = w_rd_en;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d  = ST_START;
                    avg_en_d = cmd_avg_en_i;
                    dim_d    = cmd_layer_dim_i;
                    cls_d    = cmd_classes_i;
                    total_d  = CNT_W'(calc_total(cmd_avg_en_i, cmd_layer_dim_i, cmd_classes_i));
                    issued_d = '0;
                    sent_d   = '0;
                end
            end
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                issued_d = issued_q + CNT_W'(w_rd_en);
                sent_d   = sent_q + CNT_W'(w_pop);
                if (w_pop && w_is_last) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
        start_d     = (state_d == ST_START);
        done_d      = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            avg_en_q    <= 1'b0;
            dim_q       <= '0;
            cls_q       <= '0;
            total_q     <= '0;
            issued_q    <= '0;
            sent_q      <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            start_q     <= start_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            avg_en_q    <= avg_en_d;
            dim_q       <= dim_d;
            cls_q       <= cls_d;
            total_q     <= total_d;
            issued_q    <= issued_d;
            sent_q      <= sent_d;
            inflight_q  <= inflight_d;
        end
    end

    skid_fifo2 u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (inflight_q),
        .push_data_i (pool_rd_data_i),
        .pop_i       (w_pop),
        .data_o      (m_data_o),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty)
    );

    assign cmd_ready_o      = cmd_ready_q;
    assign pool_start_o     = start_q;
    assign done_o           = done_q;
    assign busy_o           = busy_q;
    assign pool_avg_en_o    = avg_en_q;
    assign pool_layer_dim_o = dim_q;
    assign pool_classes_o   = cls_q;
    assign pool_rd_en_o     = w_rd_en;
    assign m_valid_o        = !w_fifo_empty;
    assign m_last_o         = !w_fifo_empty && w_is_last;

endmodule

`default_nettype wire
